// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and defaults for the serial adder sequencer.
package add_seq_pkg;

  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned LATENCY_DEF = 9;
  localparam int unsigned FIFO_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Latency counter width; a single bit minimum keeps degenerate latencies legal.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Operand, adder and result signals of the sequencer bundled as one port.
interface serial_add_sequencer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic             adder_start;
  logic [WIDTH:0]   adder_sum;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH:0]   res_sum;
  logic             busy;

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, adder_sum, res_ready,
    output in_ready, adder_a, adder_b, adder_start, res_valid, res_sum, busy
  );

  // Environment side: operand source, adder and result sink.
  modport master (
    output in_valid, in_a, in_b, adder_sum, res_ready,
    input  in_ready, adder_a, adder_b, adder_start, res_valid, res_sum, busy
  );

endinterface

// File: rtl/serial_add_sequencer_op_fifo.sv
// Two-entry operand-pair FIFO with 1-bit wrapping pointers and a 2-bit count.
module op_fifo
  import add_seq_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == 2'(FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage, pointers and occupancy; simultaneous push/pop leaves the count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Flow-controlled front end for the free-running serial adder: queues operand
// pairs, starts one add at a time, waits out the latency and holds the sum
// until downstream accepts it.
module serial_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input logic                   clk,
  input logic                   resetn,
  serial_add_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(LATENCY);
  localparam int unsigned DW    = 2 * WIDTH;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DW-1:0]    fifo_dout;
  logic             load_op;
  logic             cap_res;
  logic             clr_res;

  // in_ready depends only on FIFO occupancy, never on the result side.
  assign fifo_push    = bus.in_valid && !fifo_full;
  assign bus.in_ready = !fifo_full;
  assign bus.busy     = (state != IDLE) || !fifo_empty;

  op_fifo #(.DW(DW)) u_op_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (load_op),
    .din    ({bus.in_a, bus.in_b}),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: DONE chains straight into START when work is queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (bus.res_ready) state_nxt = fifo_empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes: pop/load operands, capture sum, release result.
  always_comb begin
    load_op = 1'b0;
    cap_res = 1'b0;
    clr_res = 1'b0;
    case (state)
      IDLE: load_op = !fifo_empty;
      WAIT: cap_res = (cnt == '0);
      DONE: begin
        clr_res = bus.res_ready;
        load_op = bus.res_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  // Operand registers, start pulse and latency counter; counting begins with START.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.adder_a     <= '0;
      bus.adder_b     <= '0;
      bus.adder_start <= 1'b0;
      cnt             <= '0;
    end else begin
      bus.adder_start <= load_op;
      if (load_op) begin
        bus.adder_a <= fifo_dout[DW-1:WIDTH];
        bus.adder_b <= fifo_dout[WIDTH-1:0];
        cnt         <= CNT_W'(LATENCY - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Result register, held until the downstream handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
    end else if (cap_res) begin
      bus.res_valid <= 1'b1;
      bus.res_sum   <= bus.adder_sum;
    end else if (clr_res) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule
